// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier built on a ripple chain of Full_Adder cells.
// One product per WIDTH+2 cycles with a start/busy/done handshake.

module Full_Adder (
    output logic Sum,
    output logic Carry,
    input  logic A,
    input  logic B,
    input  logic CI
);
    assign Sum   = A ^ B ^ CI;
    assign Carry = (A & B) | (A & CI) | (B & CI);
endmodule

module seq_mult_shift_add #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mcand_nxt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [PW-1:0]     p_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH:0]    carry;
    logic [PW-1:0]     acc_shift;

    // Partial product: add multiplicand to upper half when the current multiplier bit is set
    assign addend   = acc[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        Full_Adder u_fa (
            .Sum   (sum[i]),
            .Carry (carry[i+1]),
            .A     (acc[WIDTH+i]),
            .B     (addend[i]),
            .CI    (carry[i])
        );
    end

    // Carry-out is kept as the new MSB so the full 2*WIDTH product stays exact
    assign acc_shift = {carry[WIDTH], sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            P     <= p_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        p_nxt     = P;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_nxt = A;
                    acc_nxt   = {{WIDTH{1'b0}}, B};
                    cnt_nxt   = '0;
                    p_nxt     = '0;
                    state_nxt = CALC;
                    busy_nxt  = 1'b1;
                end
            end
            CALC: begin
                acc_nxt  = acc_shift;
                cnt_nxt  = cnt + CW'(1);
                busy_nxt = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    p_nxt     = acc_shift;
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add: WIDTH=4 scoreboard-checked instance plus a WIDTH=8 instance.

module tb_seq_mult_shift_add;
    logic        clk;
    logic        rst;
    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  p4;
    logic        busy4;
    logic        done4;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;
    logic        busy8;
    logic        done8;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[4];

    seq_mult_shift_add #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .P(p4), .busy(busy4), .done(done4)
    );

    seq_mult_shift_add #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .P(p8), .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse of the 4-bit instance retires one expected product
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                chk("sb_P", p4, sb_q.pop_front());
            end
        end
    end

    // One multiply on the 4-bit instance; returns negedges from start edge to done
    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        sb_q.push_back(8'(a) * 8'(b));
        @(negedge clk);
        start4 = 1'b0;
        chk("busy_rise", busy4, 1);
        lat = 1;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency4", lat, 5);
        chk("busy_at_done", busy4, 1);
        @(negedge clk);
        chk("busy_fall", busy4, 0);
        chk("done_fall", done4, 0);
    endtask

    initial begin
        int lat;
        int dones;
        logic [3:0] ha[0:17];
        logic [3:0] hb[0:17];

        vecs[0] = '{a: 4'hF, b: 4'hF, p: 8'hE1};
        vecs[1] = '{a: 4'hD, b: 4'hB, p: 8'h8F};
        vecs[2] = '{a: 4'h0, b: 4'h9, p: 8'h00};
        vecs[3] = '{a: 4'h1, b: 4'h1, p: 8'h01};

        rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_P", p4, 0);
        chk("reset_busy", busy4, 0);
        chk("reset_done", done4, 0);
        chk("reset_P8", p8, 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run4(vecs[i].a, vecs[i].b, lat);
            chk("vec_P", p4, vecs[i].p);
        end

        // Exhaustive sweep against A*B
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y), lat);
            end
        end

        // Start held during CALC and DONE must be ignored
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
        sb_q.push_back(8'h0F);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
            if (done4) dones++;
        end
        @(negedge clk);
        start4 = 1'b0;
        if (done4) dones++;
        repeat (8) begin
            @(negedge clk);
            if (done4) dones++;
        end
        chk("ignored_start_dones", dones, 1);
        chk("ignored_start_P", p4, 8'h0F);
        chk("ignored_start_idle", busy4, 0);

        // Asynchronous reset two iterations into CALC
        @(negedge clk);
        a4 = 4'hC; b4 = 4'h7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy4, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_P", p4, 0);
        chk("async_rst_busy", busy4, 0);
        chk("async_rst_done", done4, 0);
        @(negedge clk);
        rst = 1'b0;
        run4(4'h2, 4'h6, lat);
        chk("post_rst_P", p4, 8'h0C);

        // Held-high start with operands changing every cycle
        for (int i = 0; i < 18; i++) begin
            ha[i] = 4'($urandom_range(0, 15));
            hb[i] = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i <= 18; i++) begin
            @(negedge clk);
            if (i > 0) chk("held_done_timing", done4, (i % 6 == 5) ? 1 : 0);
            if (i < 18) begin
                a4 = ha[i]; b4 = hb[i]; start4 = 1'b1;
                if (i % 6 == 0) sb_q.push_back(8'(ha[i]) * 8'(hb[i]));
            end else begin
                start4 = 1'b0;
            end
        end
        repeat (8) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        // WIDTH=8 instance
        for (int t = 0; t < 3; t++) begin
            logic [7:0] x8;
            logic [7:0] y8;
            x8 = (t == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            y8 = (t == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            @(negedge clk);
            a8 = x8; b8 = y8; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = 1;
            while (!done8 && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            chk("latency8", lat, 9);
            chk("P8", p8, 16'(x8) * 16'(y8));
            @(negedge clk);
            chk("busy8_fall", busy8, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier; the stage directly downstream of the Full_Adder cell.
- Each cycle, a WIDTH-bit ripple chain of Full_Adder instances (ports Sum, Carry, A, B, CI) adds the multiplicand into the upper half of a shifting accumulator.
- Start/busy/done handshake; one product per WIDTH+2 cycles.
- Serves as the area-lean alternative to the array multiplier.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  multiplicand; captured on accepted start.
- B  in  WIDTH  multiplier; captured on accepted start.
- P  out  2*WIDTH  product register; holds last result until next accepted start.
- busy  out  1  high in CALC and DONE.
- done  out  1  single-cycle pulse in DONE; P valid.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; P=0, busy=0, done=0.
  - Internal multiplicand reg, accumulator, carry and counter all 0.
  - Takes effect immediately, including mid-CALC; in-flight result discarded.
  - First start is accepted on the first rising edge after rst deasserts.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1: mcand<=A; acc<={WIDTH zeros, B}; cnt<=0; P<=0; go to CALC.
  - start=0: remain in IDLE; P holds.
- CALC, one iteration per edge:
  - sum = acc[2W-1:W] + (acc[0] ? mcand : 0), computed by the full-adder ripple chain with CI=0; carry-out c.
  - acc <= {c, sum, acc[W-1:1]} (logical right shift of the {c, sum, lower} concatenation).
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: P<=next acc; go to DONE.
- DONE:
  - done=1, busy=1 for exactly one cycle.
  - Next edge: go to IDLE; done=0, busy=0.
- Latency:
  - start sampled at edge k; done=1 and P valid during the cycle after edge k+WIDTH.
  - With WIDTH=4, done is high between edges k+4 and k+5.
  - Earliest next accepted start is edge k+WIDTH+2 (first edge in IDLE).
- Handshake:
  - start while busy=1 (CALC or DONE) is ignored; no queueing; A/B changes have no effect.
  - Held-high start restarts a new multiply at each IDLE edge, giving back-to-back operation with one IDLE cycle between done pulses.
- Outputs busy and done are registered/state-decoded; no combinational path from start, A or B to outputs.
- Arithmetic:
  - Unsigned only.
  - The carry must be retained into the shift so 0xF*0xF does not overflow (2*WIDTH bits is exact).
  - No truncation.
- P is only updated at the CALC->DONE transition and cleared on accepted start.
- Simultaneous rst and start: rst wins.

Test Plan:
- Reset, then A=0xF, B=0xF, start 1 cycle -> busy rises next cycle; done pulses 5 cycles after start edge; P=0xE1 (225); busy falls the cycle after done.
- A=0xD, B=0xB -> P=0x8F (143); A=0x0, B=0x9 -> P=0x00; A=0x1, B=0x1 -> P=0x01; also an exhaustive 256-pair sweep checked against a behavioural A*B model.
- Pulse start at A=0x3, B=0x5, then assert start again with A=0xF, B=0xF during CALC and DONE -> ignored; P=0x0F; exactly one done pulse.
- Assert rst two cycles into CALC (A=0xC, B=0x7) -> P=0, busy=0, done=0 immediately (asynchronous, before next clock edge); a fresh start with A=0x2, B=0x6 -> P=0x0C.
- start held high with operands changing each cycle -> done every 6 cycles; each P equals the product of the operands present at that accepted start edge.
- WIDTH=8 instance: A=0xFF, B=0xFF -> P=0xFE01; done 9 cycles after start edge.
